// File: rtl/dmem_arbiter_if.sv
// Signal bundle around dmem_arbiter: core load/store ports, external master port and
// data-RAM port. The arbiter connects through the slave modport, its environment through master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              core_rd_req;
    logic [31:0]       core_rd_addr;
    logic [31:0]       core_rd_data;
    logic              core_wr_req;
    logic [3:0]        core_wr_sel;
    logic [31:0]       core_wr_addr;
    logic [31:0]       core_wr_data;
    logic              core_hold_o;

    logic              ext_req;
    logic              ext_we;
    logic [3:0]        ext_sel;
    logic [31:0]       ext_addr;
    logic [31:0]       ext_wdata;
    logic              ext_ack;
    logic [31:0]       ext_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Arbiter FSM state, exported for observation only.
    logic [1:0]        dbg_state;

    modport slave (
        input  core_rd_req, core_rd_addr, core_wr_req, core_wr_sel, core_wr_addr, core_wr_data,
        input  ext_req, ext_we, ext_sel, ext_addr, ext_wdata,
        input  ram_rdata,
        output core_rd_data, core_hold_o,
        output ext_ack, ext_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output dbg_state
    );

    modport master (
        output core_rd_req, core_rd_addr, core_wr_req, core_wr_sel, core_wr_addr, core_wr_data,
        output ext_req, ext_we, ext_sel, ext_addr, ext_wdata,
        output ram_rdata,
        input  core_rd_data, core_hold_o,
        input  ext_ack, ext_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  dbg_state
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data RAM between the core load port, the core store
// port and an external master, stalling the core and bounding external-master starvation.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    dmem_arbiter_if.slave bus
);
    // Handshakes: the core holds core_rd_req/core_wr_req and their operands stable while
    // core_hold_o=1; a core request completes in the first cycle it is asserted with
    // core_hold_o=0. The external master holds ext_req and its operands until the single
    // ext_ack cycle; ext_req seen during that ack cycle does not start a new access.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RD  = 2'd1,
        EXT_BUSY = 2'd2,
        EXT_ACK  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nxt;
    logic        wr_done, wr_done_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        ext_rd, ext_rd_nxt;
    logic [31:0] ext_rdata_q, ext_rdata_nxt;

    logic        wr_pend;
    logic        core_pend;
    logic        ext_win;
    logic        ext_grant;
    logic        core_grant;

    logic              ram_en_c;
    logic [3:0]        ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [31:0]       ram_wdata_c;
    logic              hold_c;
    logic              ack_c;
    logic [31:0]       rd_data_c;

    // Byte-offset and out-of-range address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.core_rd_addr[31:ADDR_W+2], bus.core_rd_addr[1:0],
                                bus.core_wr_addr[31:ADDR_W+2], bus.core_wr_addr[1:0],
                                bus.ext_addr[31:ADDR_W+2],     bus.ext_addr[1:0]};

    assign wr_pend   = bus.core_wr_req & ~wr_done;
    assign core_pend = bus.core_rd_req | wr_pend;
    assign ext_win   = bus.ext_req & (~core_pend | (starve_cnt == STARVE_LIM));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wr_done     <= 1'b0;
            starve_cnt  <= 4'd0;
            ext_rd      <= 1'b0;
            ext_rdata_q <= 32'd0;
        end else begin
            state       <= state_nxt;
            wr_done     <= wr_done_nxt;
            starve_cnt  <= starve_nxt;
            ext_rd      <= ext_rd_nxt;
            ext_rdata_q <= ext_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wr_done_nxt   = wr_done;
        ext_rd_nxt    = ext_rd;
        ext_rdata_nxt = ext_rdata_q;
        ram_en_c      = 1'b0;
        ram_we_c      = 4'd0;
        ram_addr_c    = '0;
        ram_wdata_c   = 32'd0;
        hold_c        = 1'b0;
        ack_c         = 1'b0;
        rd_data_c     = 32'd0;
        ext_grant     = 1'b0;
        core_grant    = 1'b0;

        case (state)
            IDLE: begin
                if (ext_win) begin
                    ext_grant   = 1'b1;
                    ram_en_c    = 1'b1;
                    ram_we_c    = bus.ext_we ? bus.ext_sel : 4'd0;
                    ram_addr_c  = bus.ext_addr[ADDR_W+1:2];
                    ram_wdata_c = bus.ext_wdata;
                    ext_rd_nxt  = ~bus.ext_we;
                    hold_c      = core_pend;
                    state_nxt   = EXT_BUSY;
                end else if (wr_pend) begin
                    // The store lands this cycle; only a pending load keeps the core stalled.
                    core_grant  = 1'b1;
                    ram_en_c    = 1'b1;
                    ram_we_c    = bus.core_wr_sel;
                    ram_addr_c  = bus.core_wr_addr[ADDR_W+1:2];
                    ram_wdata_c = bus.core_wr_data;
                    hold_c      = bus.core_rd_req;
                    wr_done_nxt = bus.core_rd_req;
                end else if (bus.core_rd_req) begin
                    core_grant  = 1'b1;
                    ram_en_c    = 1'b1;
                    ram_addr_c  = bus.core_rd_addr[ADDR_W+1:2];
                    hold_c      = 1'b1;
                    state_nxt   = CORE_RD;
                end
            end
            CORE_RD: begin
                rd_data_c = bus.ram_rdata;
                state_nxt = IDLE;
            end
            EXT_BUSY: begin
                if (ext_rd) begin
                    ext_rdata_nxt = bus.ram_rdata;
                end
                hold_c    = core_pend;
                state_nxt = EXT_ACK;
            end
            EXT_ACK: begin
                ack_c     = 1'b1;
                hold_c    = core_pend;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!hold_c) begin
            wr_done_nxt = 1'b0;
        end
    end

    // Counts core grants that overtook a waiting external request.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!bus.ext_req || ext_grant) begin
            starve_nxt = 4'd0;
        end else if (core_grant && (starve_cnt != STARVE_LIM)) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    always_comb begin
        bus.ram_en       = rst & ram_en_c;
        bus.ram_we       = rst ? ram_we_c    : 4'd0;
        bus.ram_addr     = rst ? ram_addr_c  : '0;
        bus.ram_wdata    = rst ? ram_wdata_c : 32'd0;
        bus.core_hold_o  = rst & hold_c;
        bus.core_rd_data = rst ? rd_data_c   : 32'd0;
        bus.ext_ack      = rst & ack_c;
        bus.ext_rdata    = ext_rdata_q;
        bus.dbg_state    = state;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle checks plus randomized core/external traffic
// checked against a word-level memory model and a starvation bound.
module tb_dmem_arbiter;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic rst;
    logic ram_init;

    dmem_arbiter_if #(.ADDR_W(12)) bus ();

    dmem_arbiter #(.ADDR_W(12), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks;
    int errors;
    int exp_writes;
    int seen_writes;
    int streak;
    bit mon_en;

    logic [31:0] ref_mem [4096];
    logic [31:0] ram_mem [4096];
    logic [31:0] exp_q [$];
    logic [31:0] ext_exp_q [$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / model ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] data);
        ref_mem[addr[13:2]] = merge(ref_mem[addr[13:2]], data, sel);
        exp_writes++;
    endtask

    // Synchronous single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= init_word(i);
        end else if (bus.ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    // Monitors: RAM write count and consecutive core grants while ext_req waits.
    always @(negedge clk) begin
        if (bus.ram_en && (bus.ram_we != 4'd0)) seen_writes++;
        if (mon_en) begin
            if (!bus.ext_req) begin
                streak = 0;
            end else if (bus.ram_en) begin
                if (bus.ram_addr[11]) begin
                    check("starve_bound", 32'(streak > STARVE_MAX), 32'd0);
                    streak = 0;
                end else begin
                    streak++;
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic core_op(input bit wr, input logic [31:0] waddr, input logic [3:0] sel,
                           input logic [31:0] wdata, input bit rd, input logic [31:0] raddr);
        int n;
        bus.core_wr_req  = wr;
        bus.core_wr_addr = waddr;
        bus.core_wr_sel  = sel;
        bus.core_wr_data = wdata;
        bus.core_rd_req  = rd;
        bus.core_rd_addr = raddr;
        if (wr) model_store(waddr, sel, wdata);
        if (rd) exp_q.push_back(ref_mem[raddr[13:2]]);
        n = 0;
        @(negedge clk);
        while (bus.core_hold_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.core_hold_o) check("core_timeout", 32'd1, 32'd0);
        else if (rd) check("core_rd", bus.core_rd_data, exp_q.pop_front());
        @(posedge clk);
        #1;
        bus.core_wr_req = 1'b0;
        bus.core_rd_req = 1'b0;
    endtask

    task automatic ext_op(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata);
        int n;
        bus.ext_req   = 1'b1;
        bus.ext_we    = we;
        bus.ext_addr  = addr;
        bus.ext_sel   = sel;
        bus.ext_wdata = wdata;
        if (we) model_store(addr, sel, wdata);
        else ext_exp_q.push_back(ref_mem[addr[13:2]]);
        n = 0;
        @(negedge clk);
        while (!bus.ext_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ext_ack) check("ext_timeout", 32'd1, 32'd0);
        else if (!we) check("ext_rd", bus.ext_rdata, ext_exp_q.pop_front());
        @(posedge clk);
        #1;
        bus.ext_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wr_before;
        int grants;
        int grant_cyc;
        int ack_cyc;
        logic [31:0] w;

        checks = 0; errors = 0; exp_writes = 0; seen_writes = 0; streak = 0; mon_en = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        rst = 1'b0; ram_init = 1'b1;
        bus.core_rd_req = 1'b1; bus.core_rd_addr = 32'h100;
        bus.core_wr_req = 1'b0; bus.core_wr_sel = 4'd0; bus.core_wr_addr = 32'd0; bus.core_wr_data = 32'd0;
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_sel = 4'hF; bus.ext_addr = 32'h200; bus.ext_wdata = 32'h1;
        bus.ram_rdata = 32'd0;

        // Reset holds all outputs low even with requests present.
        @(negedge clk);
        check("rst_ram_en", 32'(bus.ram_en), 32'd0);
        check("rst_hold", 32'(bus.core_hold_o), 32'd0);
        check("rst_ack", 32'(bus.ext_ack), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        bus.core_rd_req = 1'b0; bus.ext_req = 1'b0; bus.ext_we = 1'b0;
        repeat (2) @(posedge clk);
        #1; ram_init = 1'b0; rst = 1'b1;
        @(posedge clk); #1;

        // Store only: written same cycle, no stall.
        bus.core_wr_req = 1'b1; bus.core_wr_addr = 32'h100; bus.core_wr_sel = 4'hF; bus.core_wr_data = 32'hDEADBEEF;
        model_store(32'h100, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("t2_ram_en", 32'(bus.ram_en), 32'd1);
        check("t2_ram_we", 32'(bus.ram_we), 32'hF);
        check("t2_ram_addr", 32'(bus.ram_addr), 32'h40);
        check("t2_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
        check("t2_hold", 32'(bus.core_hold_o), 32'd0);
        @(posedge clk); #1;
        bus.core_wr_req = 1'b0;

        // Load: one stall cycle, data the next.
        bus.core_rd_req = 1'b1; bus.core_rd_addr = 32'h100;
        @(negedge clk);
        check("t3_c0_hold", 32'(bus.core_hold_o), 32'd1);
        check("t3_c0_ram_en", 32'(bus.ram_en), 32'd1);
        check("t3_c0_ram_we", 32'(bus.ram_we), 32'd0);
        check("t3_c0_ram_addr", 32'(bus.ram_addr), 32'h40);
        @(negedge clk);
        check("t3_c1_data", bus.core_rd_data, 32'hDEADBEEF);
        check("t3_c1_hold", 32'(bus.core_hold_o), 32'd0);
        @(posedge clk); #1;
        bus.core_rd_req = 1'b0;

        // Store + load same address: store first, single write, new value returned.
        wr_before = seen_writes;
        bus.core_wr_req = 1'b1; bus.core_wr_addr = 32'h104; bus.core_wr_sel = 4'hF; bus.core_wr_data = 32'h12345678;
        bus.core_rd_req = 1'b1; bus.core_rd_addr = 32'h104;
        model_store(32'h104, 4'hF, 32'h12345678);
        @(negedge clk);
        check("t4_c0_hold", 32'(bus.core_hold_o), 32'd1);
        check("t4_c0_ram_we", 32'(bus.ram_we), 32'hF);
        check("t4_c0_ram_addr", 32'(bus.ram_addr), 32'h41);
        @(negedge clk);
        check("t4_c1_ram_en", 32'(bus.ram_en), 32'd1);
        check("t4_c1_ram_we", 32'(bus.ram_we), 32'd0);
        check("t4_c1_hold", 32'(bus.core_hold_o), 32'd1);
        @(negedge clk);
        check("t4_c2_data", bus.core_rd_data, 32'h12345678);
        check("t4_c2_hold", 32'(bus.core_hold_o), 32'd0);
        @(posedge clk); #1;
        bus.core_wr_req = 1'b0; bus.core_rd_req = 1'b0;
        check("t4_writes", 32'(seen_writes - wr_before), 32'd1);

        // Ext partial write then read back.
        ext_op(1'b1, 32'h200, 4'b0011, 32'h0000AAAA);
        ext_op(1'b0, 32'h200, 4'h0, 32'h0);
        w = init_word(12'h080);
        check("t6_low", 32'(bus.ext_rdata[15:0]), 32'h0000AAAA);
        check("t6_high", 32'(bus.ext_rdata[31:16]), 32'(w[31:16]));
        @(negedge clk);
        check("t6_ack_pulse", 32'(bus.ext_ack), 32'd0);
        @(posedge clk); #1;

        // Starvation: continuous core loads versus a waiting ext read.
        bus.core_rd_req = 1'b1; bus.core_rd_addr = 32'h100;
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h200;
        grants = 0; grant_cyc = -1; ack_cyc = -1;
        for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (bus.ram_en && bus.ram_addr == 12'h040 && grant_cyc < 0) grants++;
            if (bus.ram_en && bus.ram_addr == 12'h080) grant_cyc = c;
            if (bus.ext_ack) begin
                ack_cyc = c;
                check("t5_ext_rd", bus.ext_rdata, ref_mem[12'h080]);
            end
            @(posedge clk); #1;
        end
        check("t5_core_grants", 32'(grants), 32'd4);
        check("t5_ack_latency", 32'(ack_cyc - grant_cyc), 32'd2);
        bus.ext_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.core_hold_o) break;
        end
        @(posedge clk); #1;
        bus.core_rd_req = 1'b0;

        // Reset in the middle of CORE_RD.
        bus.core_rd_req = 1'b1; bus.core_rd_addr = 32'h104;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_core_rd_data", bus.core_rd_data, 32'd0);
        check("t1_hold", 32'(bus.core_hold_o), 32'd0);
        check("t1_ram_en", 32'(bus.ram_en), 32'd0);
        check("t1_ext_rdata", bus.ext_rdata, 32'd0);
        check("t1_state", 32'(bus.dbg_state), 32'd0);
        bus.core_rd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t1_post_data", bus.core_rd_data, 32'd0);
        check("t1_post_state", 32'(bus.dbg_state), 32'd0);
        @(posedge clk); #1;

        // Randomized concurrent traffic in disjoint core/ext address regions.
        mon_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    int r;
                    logic [11:0] ww, rw;
                    logic [31:0] up;
                    r  = $urandom_range(0, 2);
                    ww = 12'($urandom_range(0, 15));
                    rw = ($urandom_range(0, 1) == 1) ? ww : 12'($urandom_range(0, 15));
                    up = $urandom;
                    core_op(r != 1, {up[17:0], ww, up[19:18]}, 4'($urandom_range(1, 15)), $urandom,
                            r != 0, {up[31:14], rw, up[21:20]});
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [11:0] ew;
                    logic [31:0] up;
                    ew = 12'($urandom_range(12'h800, 12'h80F));
                    up = $urandom;
                    ext_op($urandom_range(0, 1) == 1, {up[17:0], ew, up[19:18]},
                           4'($urandom_range(1, 15)), $urandom);
                    repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
                end
            end
        join
        mon_en = 1'b0;
        @(posedge clk); #1;

        check("wr_count", 32'(seen_writes), 32'(exp_writes));
        check("exp_q_empty", 32'(exp_q.size() + ext_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
